// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO.
// Registers: 0x0 TXDATA (wo), 0x4 STATUS, 0x8 CTRL, 0xC reserved.
// Build option: UART_TX_FIFO_EN selects a 2^FIFO_DEPTH_POT FIFO; otherwise
// a single holding register (depth 1) is used.
module uart_tx_periph #(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned FIFO_DEPTH_POT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [3:0]  addr_i,
    input  logic        read_i,
    input  logic [3:0]  wsel_byte_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;
    logic          tx_en_q, tx_en_d;
    logic          irq_en_q, irq_en_d;
    logic [31:0]   rdata_q, rdata_d;

    logic       wr_en, rd_en, push_req, push_ok, pop, ovf_clr, ctrl_wr;
    logic [1:0] reg_sel;
    logic       fifo_full, fifo_empty, busy;
    logic [7:0] fifo_head, fill;
    logic       unused_bits;

    assign wr_en    = en_i & ~read_i;
    assign rd_en    = en_i & read_i;
    assign reg_sel  = addr_i[3:2];
    assign push_req = wr_en && (reg_sel == 2'd0) && wsel_byte_i[0];
    assign ovf_clr  = wr_en && (reg_sel == 2'd1) && wsel_byte_i[0] && wdata_i[3];
    assign ctrl_wr  = wr_en && (reg_sel == 2'd2) && wsel_byte_i[0];
    // Full is judged on the registered state, so a same-cycle pop never frees room.
    assign push_ok  = push_req & ~fifo_full;
    assign busy     = (state_q != S_IDLE);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_POT;

    logic [7:0]                mem_q [DEPTH];
    logic [FIFO_DEPTH_POT-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_DEPTH_POT:0]   cnt_q, cnt_d;

    assign fifo_full  = (cnt_q == (FIFO_DEPTH_POT + 1)'(DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign fifo_head  = mem_q[rptr_q];
    assign fill       = 8'(cnt_q);
    assign unused_bits = ^{addr_i[1:0], wdata_i[31:8], wsel_byte_i[3:1]};

    // FIFO pointer and occupancy update
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop)     rptr_d = rptr_q + 1'b1;
        if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push_ok) cnt_d = cnt_q - 1'b1;
    end

    // FIFO pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i[7:0];
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;

    assign fifo_full  = hold_vld_q;
    assign fifo_empty = ~hold_vld_q;
    assign fifo_head  = hold_q;
    assign fill       = {7'd0, hold_vld_q};
    assign unused_bits = ^{addr_i[1:0], wdata_i[31:8], wsel_byte_i[3:1],
                           FIFO_DEPTH_POT[0]};

    // Holding register load/drain
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (pop) hold_vld_d = 1'b0;
        if (push_ok) begin
            hold_d     = wdata_i[7:0];
            hold_vld_d = 1'b1;
        end
    end

    // Holding register state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    // Transmit FSM; STOP chains straight into START so frames are gapless
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (tx_en_q && !fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
        // Line level follows the next state so tx_o is a clean flop output
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Register file writes and registered read mux
    always_comb begin
        overflow_d = overflow_q;
        tx_en_d    = tx_en_q;
        irq_en_d   = irq_en_q;
        rdata_d    = rdata_q;
        if (push_req && fifo_full) overflow_d = 1'b1;
        else if (ovf_clr)          overflow_d = 1'b0;
        if (ctrl_wr) begin
            tx_en_d  = wdata_i[0];
            irq_en_d = wdata_i[1];
        end
        if (rd_en) begin
            case (reg_sel)
                2'd1:    rdata_d = {16'd0, fill, 4'd0, overflow_q, busy, fifo_empty, fifo_full};
                2'd2:    rdata_d = {30'd0, irq_en_q, tx_en_q};
                default: rdata_d = '0;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            irq_en_q   <= irq_en_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
    assign tx_o    = tx_q;
    assign irq_o   = irq_en_q & fifo_empty & ~busy;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph. Reads and serial frames push their
// expected values into queues; independent monitors pop and compare.
module tb_uart_tx_periph;

    localparam int DIV = 20;  // 2 MHz / 100 kbaud

    logic        clk = 1'b0;
    logic        rst, en, read;
    logic [3:0]  addr, be;
    logic [31:0] wdata, rdata;
    logic        tx, irq;

    always #5 clk = ~clk;

    uart_tx_periph #(
        .CLK_FREQ_HZ    (2_000_000),
        .BAUD           (100_000),
        .FIFO_DEPTH_POT (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .addr_i      (addr),
        .read_i      (read),
        .wsel_byte_i (be),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .tx_o        (tx),
        .irq_o       (irq)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [31:0] exp_rd_q [$];
    logic [7:0]  exp_tx_q [$];
    logic        rd_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_vld <= en && read && !rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read monitor: rdata is compared one cycle after each read access
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rd_vld) begin
                if (exp_rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_unexpected: got 0x%0h, expected no read", rdata);
                end else begin
                    e = exp_rd_q.pop_front();
                    chk("rdata", rdata, e);
                end
            end
        end
    end

    // Serial monitor: samples mid-bit from the falling start edge
    initial begin
        int rcnt;
        int k;
        logic act;
        logic [9:0] fr;
        logic [7:0] e;
        act = 1'b0; rcnt = 0; fr = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1; rcnt = 0; fr = '0;
                end
            end else begin
                rcnt++;
                if (rcnt % DIV == DIV / 2) begin
                    k = rcnt / DIV;
                    fr[k] = tx;
                    if (k == 9) begin
                        act = 1'b0;
                        if (exp_tx_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL tx_unexpected: got frame 0x%0h, expected none", fr);
                        end else begin
                            e = exp_tx_q.pop_front();
                            chk("tx_frame", {22'd0, fr}, {22'd0, 1'b1, e, 1'b0});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        en = 1'b1; read = 1'b0; addr = a; wdata = d; be = b;
        @(negedge clk);
        en = 1'b0; be = '0;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp);
        en = 1'b1; read = 1'b1; addr = a; be = '0;
        exp_rd_q.push_back(exp);
        @(negedge clk);
        en = 1'b0; read = 1'b0;
    endtask

    task automatic wait_tx_low(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            if (tx === 1'b0) begin c = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_irq(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            if (irq === 1'b1) begin c = cyc; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        int fall, c, lowc, target;
        rst = 1'b1; en = 1'b0; read = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;

        // Reset state and register map
        bus_rd(4'h4, 32'h2);
        bus_rd(4'h0, 32'h0);
        bus_rd(4'hC, 32'h0);
        bus_wr(4'h8, 32'h3, 4'b0000);
        bus_rd(4'h8, 32'h0);
        bus_wr(4'h8, 32'hFFFF_FFFE, 4'b0001);
        bus_rd(4'h8, 32'h2);
        @(negedge clk);
        chk("rdata_hold", rdata, 32'h2);
        chk("irq_idle_empty", {31'd0, irq}, 32'd1);
        bus_wr(4'hC, 32'hFFFF_FFFF, 4'hF);
        bus_rd(4'h8, 32'h2);

        // Single frame: latency, start length, frame length, irq timing
        bus_wr(4'h8, 32'h3, 4'b0001);
        exp_tx_q.push_back(8'hA5);
        bus_wr(4'h0, 32'hA5, 4'b0001);
        chk("tx_n1_high", {31'd0, tx}, 32'd1);
        chk("irq_queued", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("tx_n2_low", {31'd0, tx}, 32'd0);
        fall = cyc;
        lowc = 1;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (tx !== 1'b0) break;
            lowc++;
        end
        chk("start_len", lowc, DIV);
        bus_rd(4'h4, 32'h6);
        chk("irq_busy", {31'd0, irq}, 32'd0);
        wait_irq(20 * DIV, c);
        chk("frame_len", c - fall, 10 * DIV);
        bus_rd(4'h4, 32'h2);

        // Overflow and back-to-back frames
        bus_wr(4'h8, 32'h0, 4'b0001);
`ifdef UART_TX_FIFO_EN
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_tx_q.push_back(8'(8'h10 + i));
            bus_wr(4'h0, 32'h10 + i, 4'b0001);
        end
        bus_rd(4'h4, 32'h1009);
        bus_wr(4'h4, 32'h8, 4'b0001);
        bus_rd(4'h4, 32'h1001);
        bus_wr(4'h8, 32'h3, 4'b0001);
        wait_tx_low(10, fall);
        wait_irq(170 * DIV, c);
        chk("burst_len", c - fall, 160 * DIV);
`else
        exp_tx_q.push_back(8'h3C);
        bus_wr(4'h0, 32'h3C, 4'b0001);
        bus_wr(4'h0, 32'hC3, 4'b0001);
        bus_rd(4'h4, 32'h0109);
        bus_wr(4'h4, 32'h8, 4'b0001);
        bus_rd(4'h4, 32'h0101);
        bus_wr(4'h8, 32'h3, 4'b0001);
        wait_tx_low(10, fall);
        wait_irq(20 * DIV, c);
        chk("single_len", c - fall, 10 * DIV);
        repeat (3 * DIV) @(negedge clk);
        chk("holding_one_only", {31'd0, tx}, 32'd1);
`endif
        bus_rd(4'h4, 32'h2);

        // tx_en cleared mid-frame: frame completes, queued byte retained
        exp_tx_q.push_back(8'h96);
        exp_tx_q.push_back(8'h69);
        bus_wr(4'h8, 32'h1, 4'b0001);
        bus_wr(4'h0, 32'h96, 4'b0001);
        wait_tx_low(10, fall);
        bus_wr(4'h0, 32'h69, 4'b0001);
        bus_wr(4'h8, 32'h0, 4'b0001);
        repeat (12 * DIV) @(negedge clk);
`ifdef UART_TX_FIFO_EN
        bus_rd(4'h4, 32'h0100);
`else
        bus_rd(4'h4, 32'h0101);
`endif
        chk("paused_idle_tx", {31'd0, tx}, 32'd1);
        bus_wr(4'h8, 32'h1, 4'b0001);
        wait_tx_low(10, fall);
        repeat (11 * DIV) @(negedge clk);
        bus_rd(4'h4, 32'h2);

        // Reset during data bit 3 discards frame and queue
        bus_wr(4'h0, 32'h5A, 4'b0001);
        wait_tx_low(10, fall);
        bus_wr(4'h0, 32'h77, 4'b0001);
        target = fall + 4 * DIV + DIV / 2;
        for (int i = 0; i < 10 * DIV && cyc < target; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_midframe_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_rd(4'h4, 32'h2);
        bus_wr(4'h8, 32'h1, 4'b0001);
        repeat (25 * DIV) @(negedge clk);
        chk("no_frame_after_rst", {31'd0, tx}, 32'd1);
        bus_rd(4'h4, 32'h2);

        @(negedge clk);
        chk("rd_queue_drained", exp_rd_q.size(), 0);
        chk("tx_queue_drained", exp_tx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
